// File: rtl/la_capture_buffer.sv
// -----------------------------------------------------------------------------
// la_capture_buffer
//
// Front end of the logic-analyzer FTDI fast-serial transmitter. The 8 probe
// inputs are synchronised and sampled at a programmable rate. Once armed, the
// block waits for a masked pattern trigger and then stores a fixed number of
// samples in a small FIFO. The serializer drains that FIFO one byte at a time
// over a valid/ready handshake.
//
// Ports:
//   clk          system clock (also FSCLK downstream)
//   rst_n        asynchronous, active-low reset
//   logic_input  8 asynchronous probe inputs
//   arm          one-cycle request to start an acquisition (honoured in IDLE)
//   trig_mask    1 = bit takes part in the trigger compare
//   trig_value   required level for each masked bit
//   div          sample period minus 1, in clk cycles (0 = every cycle)
//   out_data     byte at the FIFO head (0 while the FIFO is empty)
//   out_valid    FIFO not empty
//   out_ready    consumer takes the head byte this cycle
//   armed        waiting for the trigger
//   capturing    storing post-trigger samples
//   overflow     sticky: a capture sample was dropped on a full FIFO
// -----------------------------------------------------------------------------
module la_capture_buffer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int CAPTURE_LEN = 1024,
  parameter int DIV_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       logic_input,
  input  logic             arm,
  input  logic [7:0]       trig_mask,
  input  logic [7:0]       trig_value,
  input  logic [DIV_W-1:0] div,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             armed,
  output logic             capturing,
  output logic             overflow
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int PTR_W  = DEPTH_LOG2 + 1;
  localparam int SCNT_W = $clog2(CAPTURE_LEN + 1);

  // scnt value seen on the strobe that produces the final sample
  localparam logic [SCNT_W-1:0] LAST_CNT = SCNT_W'(CAPTURE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]       sync1;
  logic [7:0]       smp;
  logic [DIV_W-1:0] dcnt;
  logic [SCNT_W-1:0] scnt;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [7:0]       mem [DEPTH];

  logic trig_hit;
  logic strobe;
  logic last_sample;
  logic push;
  logic push_ok;
  logic pop;
  logic full;
  logic empty;
  logic drain_done;

  // Two-flop synchroniser; everything downstream looks only at smp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'h00;
      smp   <= 8'h00;
    end else begin
      sync1 <= logic_input;
      smp   <= sync1;
    end
  end

  assign trig_hit    = ((smp ^ trig_value) & trig_mask) == 8'h00;
  assign strobe      = (dcnt == div);
  assign last_sample = (scnt == LAST_CNT);

  // FIFO status. The extra pointer MSB tells full apart from empty.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  // A push into a full FIFO only fits if the head leaves in the same cycle.
  assign push_ok    = push && (!full || pop);

  // DRAIN may leave as soon as the last byte is being popped.
  assign drain_done = empty || (pop && (rd_ptr_inc == wr_ptr));

  // Head byte is forced to zero while empty so stale RAM never shows.
  assign out_data   = out_valid ? mem[rd_ptr[DEPTH_LOG2-1:0]] : 8'h00;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic. arm only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (trig_hit) begin
          state_nxt = (CAPTURE_LEN == 1) ? DRAIN : CAPTURE;
        end
      end
      CAPTURE: begin
        if (strobe && last_sample) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: status flags and the FIFO write request. The trigger sample
  // itself is the first stored sample.
  always_comb begin
    armed     = (state == ARMED);
    capturing = (state == CAPTURE);
    push      = ((state == ARMED) && trig_hit) ||
                ((state == CAPTURE) && strobe);
  end

  // Sample-rate divider. It restarts on the trigger write so the next sample
  // lands exactly div+1 cycles later; the >= guards against div being lowered
  // below the running count mid-capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= '0;
    end else if ((state == ARMED) && trig_hit) begin
      dcnt <= '0;
    end else if (state == CAPTURE) begin
      dcnt <= (dcnt >= div) ? '0 : dcnt + DIV_W'(1);
    end else begin
      dcnt <= '0;
    end
  end

  // Sample counter. Counts attempted writes, so a dropped sample still uses
  // up one slot of the capture length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= '0;
    end else if ((state == ARMED) && trig_hit) begin
      scnt <= SCNT_W'(1);
    end else if ((state == CAPTURE) && strobe) begin
      scnt <= scnt + SCNT_W'(1);
    end else if (state == IDLE) begin
      scnt <= '0;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
    end
  end

  // FIFO storage. No reset needed: the pointers define what is valid. On a
  // full push+pop the write slot is the one being vacated, so the head the
  // consumer is reading this cycle is never disturbed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= smp;
    end
  end

  // Sticky overflow, cleared only by an accepted arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if ((state == IDLE) && arm) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_la_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_la_capture_buffer
//
// Directed bench for la_capture_buffer (DEPTH_LOG2=4, CAPTURE_LEN=20).
// Inputs change on the falling edge; outputs are sampled 1 ns before each
// rising edge, which is also where accepted bytes are collected.
// -----------------------------------------------------------------------------
module tb_la_capture_buffer;

  localparam int DEPTH_LOG2  = 4;
  localparam int CAPTURE_LEN = 20;
  localparam int DIV_W       = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       logic_input;
  logic             arm;
  logic [7:0]       trig_mask;
  logic [7:0]       trig_value;
  logic [DIV_W-1:0] div;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             armed;
  logic             capturing;
  logic             overflow;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] rx_q[$];
  bit         ramp_en     = 1'b0;

  la_capture_buffer #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CAPTURE_LEN(CAPTURE_LEN),
    .DIV_W      (DIV_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .logic_input(logic_input),
    .arm        (arm),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .div        (div),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .armed      (armed),
    .capturing  (capturing),
    .overflow   (overflow)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs n clock cycles starting from a falling edge. Bytes handed over at a
  // rising edge are recorded just before it; the probe ramp advances on the
  // following falling edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      #4;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        rx_q.push_back(out_data);
      end
      @(negedge clk);
      if (ramp_en) begin
        logic_input = logic_input + 8'd1;
      end
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    applyStimulus(1);
    arm = 1'b0;
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) begin
      return {24'h0, rx_q[i]};
    end
    return 32'hDEAD_BEEF;
  endfunction

  // Compares the collected bytes with first, first+step, first+2*step ...
  task automatic check_sequence(input string tag, input logic [7:0] first,
                                input int step, input int n);
    logic [7:0] exp;
    checkOutput({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      exp = first + 8'(i * step);
      checkOutput($sformatf("%s[%0d]", tag, i), rx_at(i), {24'h0, exp});
    end
  endtask

  initial begin
    int waited;

    rst_n       = 1'b0;
    arm         = 1'b0;
    logic_input = 8'h00;
    trig_mask   = 8'h00;
    trig_value  = 8'h00;
    div         = '0;
    out_ready   = 1'b0;

    // Reset values
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data",  out_data,  0);
    checkOutput("rst_armed",     armed,     0);
    checkOutput("rst_capturing", capturing, 0);
    checkOutput("rst_overflow",  overflow,  0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3);

    // Immediate trigger, div=0. Arming while the probe ramps 0x10, 0x11, 0x12:
    // the ARMED cycle sees 0x11 in smp, so that is the trigger sample.
    $display("[TB] immediate trigger, div=0");
    div = '0; trig_mask = 8'h00; out_ready = 1'b1;
    logic_input = 8'h10; ramp_en = 1'b1;
    rx_q.delete();
    applyStimulus(2);
    pulse_arm();
    checkOutput("t1_armed", armed, 1);
    applyStimulus(1);
    checkOutput("t1_capturing", capturing, 1);
    checkOutput("t1_first_valid", out_valid, 1);
    checkOutput("t1_first_data", out_data, 8'h11);
    applyStimulus(40);
    check_sequence("t1_seq", 8'h11, 1, 20);
    checkOutput("t1_end_valid", out_valid, 0);
    checkOutput("t1_end_armed", armed, 0);
    checkOutput("t1_end_capturing", capturing, 0);

    // Pattern trigger on upper nibble == A
    $display("[TB] pattern trigger mask=F0 value=A0");
    trig_mask = 8'hF0; trig_value = 8'hA0;
    logic_input = 8'h00;
    rx_q.delete();
    applyStimulus(2);
    pulse_arm();
    checkOutput("t2_armed", armed, 1);
    waited = 0;
    while (armed === 1'b1 && waited < 400) begin
      applyStimulus(1);
      waited++;
    end
    checkOutput("t2_trig_timeout", armed, 0);
    checkOutput("t2_no_early_output", rx_q.size(), 0);
    checkOutput("t2_head", out_data, 8'hA0);
    checkOutput("t2_capturing", capturing, 1);
    applyStimulus(40);
    check_sequence("t2_seq", 8'hA0, 1, 20);
    checkOutput("t2_end_valid", out_valid, 0);
    checkOutput("t2_end_capturing", capturing, 0);

    // Decimation div=3: samples 4 cycles apart
    $display("[TB] decimation div=3");
    div = 16'd3; trig_mask = 8'h00;
    logic_input = 8'h30;
    rx_q.delete();
    applyStimulus(2);
    pulse_arm();
    applyStimulus(100);
    check_sequence("t3_seq", 8'h31, 4, 20);
    checkOutput("t3_end_valid", out_valid, 0);
    checkOutput("t3_end_capturing", capturing, 0);

    // Backpressure: 20 samples into a 16-deep FIFO with nobody reading
    $display("[TB] backpressure and overflow");
    div = '0; out_ready = 1'b0;
    logic_input = 8'h50;
    rx_q.delete();
    applyStimulus(2);
    pulse_arm();
    applyStimulus(25);
    checkOutput("t4_overflow", overflow, 1);
    checkOutput("t4_valid", out_valid, 1);
    checkOutput("t4_head", out_data, 8'h51);
    checkOutput("t4_drain_capturing", capturing, 0);
    pulse_arm();
    checkOutput("t4_arm_in_drain", armed, 0);
    checkOutput("t4_overflow_kept", overflow, 1);
    out_ready = 1'b1;
    applyStimulus(30);
    check_sequence("t4_seq", 8'h51, 1, 16);
    checkOutput("t4_end_valid", out_valid, 0);
    checkOutput("t4_overflow_sticky", overflow, 1);

    // Full FIFO with a same-cycle pop, then irregular reading
    $display("[TB] full with simultaneous pop, random ready");
    div = 16'd1; out_ready = 1'b0;
    logic_input = 8'h80;
    rx_q.delete();
    applyStimulus(2);
    pulse_arm();
    checkOutput("t5_arm_clears_overflow", overflow, 0);
    checkOutput("t5_armed", armed, 1);
    applyStimulus(32);
    checkOutput("t5_full_valid", out_valid, 1);
    checkOutput("t5_full_head", out_data, 8'h81);
    checkOutput("t5_full_no_overflow", overflow, 0);
    out_ready = 1'b1;
    applyStimulus(1);
    checkOutput("t5_push_pop_overflow", overflow, 0);
    applyStimulus(8);
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      applyStimulus(1);
    end
    out_ready = 1'b1;
    applyStimulus(40);
    check_sequence("t5_seq", 8'h81, 2, 20);
    checkOutput("t5_end_overflow", overflow, 0);
    checkOutput("t5_end_valid", out_valid, 0);

    // Asynchronous reset in the middle of a capture
    $display("[TB] reset mid-capture");
    div = '0; out_ready = 1'b0;
    logic_input = 8'hC0;
    rx_q.delete();
    applyStimulus(2);
    pulse_arm();
    applyStimulus(5);
    checkOutput("t6_capturing", capturing, 1);
    checkOutput("t6_valid", out_valid, 1);
    checkOutput("t6_head", out_data, 8'hC1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", out_valid, 0);
    checkOutput("t6_rst_data", out_data, 0);
    checkOutput("t6_rst_capturing", capturing, 0);
    checkOutput("t6_rst_armed", armed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3);
    checkOutput("t6_post_valid", out_valid, 0);
    checkOutput("t6_post_armed", armed, 0);
    checkOutput("t6_post_capturing", capturing, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
